// File: rtl/alu_sequencer.sv
// Sequences a 16-bit ADD/SUB/AND/ORR/CMP through an external 8-bit ALU, low byte then high byte.
// Latency: done pulses 3 cycles after accept for a valid op, 1 cycle after accept for an invalid op.
// Backpressure: start is sampled only in IDLE; requests arriving while busy are dropped, never queued.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, op, opa, opb      request and operands (latched on accept)
//   alu_opt/numa/numb/ci     drive to the external combinational 8-bit ALU
//   alu_s/co/zero            ALU result byte, carry/borrow out, zero flag (same cycle)
//   busy, done               in-flight indicator, one-cycle completion pulse
//   result, carry, zero, err registered outputs, held between operations

module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic [2:0]  alu_opt,
  output logic [7:0]  alu_numa,
  output logic [7:0]  alu_numb,
  output logic        alu_ci,
  input  logic [7:0]  alu_s,
  input  logic        alu_co,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero,
  output logic        err
);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_ORR = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  function automatic logic op_is_valid(input logic [2:0] o);
    return (o >= OP_ADD) && (o <= OP_CMP);
  endfunction

  // Arithmetic ops chain carry/borrow between bytes; logic ops do not.
  function automatic logic op_is_arith(input logic [2:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_CMP);
  endfunction

  state_e      state_q, state_d;

  // Latched request
  logic [2:0]  op_q, op_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;

  // Per-byte ALU captures
  logic [7:0]  lo_s_q, lo_s_d;
  logic        lo_co_q, lo_co_d;
  logic        lo_z_q, lo_z_d;
  logic [7:0]  hi_s_q, hi_s_d;
  logic        hi_co_q, hi_co_d;
  logic        hi_z_q, hi_z_d;

  // Registered outputs
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      lo_s_q   <= '0;
      lo_co_q  <= 1'b0;
      lo_z_q   <= 1'b0;
      hi_s_q   <= '0;
      hi_co_q  <= 1'b0;
      hi_z_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      lo_s_q   <= lo_s_d;
      lo_co_q  <= lo_co_d;
      lo_z_q   <= lo_z_d;
      hi_s_q   <= hi_s_d;
      hi_co_q  <= hi_co_d;
      hi_z_q   <= hi_z_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Invalid ops skip the ALU entirely and just report err.
          state_d = op_is_valid(op) ? S_LO : S_FIN;
        end
      end
      S_LO:    state_d = S_HI;
      S_HI:    state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    lo_s_d   = lo_s_q;
    lo_co_d  = lo_co_q;
    lo_z_d   = lo_z_q;
    hi_s_d   = hi_s_q;
    hi_co_d  = hi_co_q;
    hi_z_d   = hi_z_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    done_d   = 1'b0;
    // busy covers accept through the done cycle: FIN->IDLE leaves busy set
    // for exactly the cycle in which done is high.
    busy_d   = (state_q != S_IDLE) || start;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          opa_d = opa;
          opb_d = opb;
        end
      end
      S_LO: begin
        lo_s_d  = alu_s;
        lo_co_d = alu_co;
        lo_z_d  = alu_zero;
      end
      S_HI: begin
        hi_s_d  = alu_s;
        hi_co_d = alu_co;
        hi_z_d  = alu_zero;
      end
      S_FIN: begin
        done_d = 1'b1;
        if (op_is_valid(op_q)) begin
          err_d   = 1'b0;
          // Logic ops never report a carry, whatever the ALU says.
          carry_d = op_is_arith(op_q) ? hi_co_q : 1'b0;
          zero_d  = lo_z_q & hi_z_q;
          // CMP only updates flags; the previous result is preserved.
          if (op_q != OP_CMP) begin
            result_d = {hi_s_q, lo_s_q};
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU drive outputs (decoded from state)
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_opt  = '0;
    alu_numa = '0;
    alu_numb = '0;
    alu_ci   = 1'b0;
    case (state_q)
      S_LO: begin
        alu_opt  = op_q;
        alu_numa = opa_q[7:0];
        alu_numb = opb_q[7:0];
        alu_ci   = 1'b0;
      end
      S_HI: begin
        alu_opt  = op_q;
        alu_numa = opa_q[15:8];
        alu_numb = opb_q[15:8];
        alu_ci   = op_is_arith(op_q) ? lo_co_q : 1'b0;
      end
      default: begin
        alu_opt  = '0;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [2:0]  alu_opt;
  logic [7:0]  alu_numa;
  logic [7:0]  alu_numb;
  logic        alu_ci;
  logic [7:0]  alu_s;
  logic        alu_co;
  logic        alu_zero;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .alu_opt  (alu_opt),
    .alu_numa (alu_numa),
    .alu_numb (alu_numb),
    .alu_ci   (alu_ci),
    .alu_s    (alu_s),
    .alu_co   (alu_co),
    .alu_zero (alu_zero),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit ALU: co is carry for ADD, borrow for SUB/CMP.
  logic [8:0] alu_tmp;
  always_comb begin
    alu_tmp = 9'd0;
    case (alu_opt)
      3'd1:    alu_tmp = {1'b0, alu_numa} + {1'b0, alu_numb} + {8'd0, alu_ci};
      3'd2,
      3'd5:    alu_tmp = {1'b0, alu_numa} - {1'b0, alu_numb} - {8'd0, alu_ci};
      3'd3:    alu_tmp = {1'b0, alu_numa & alu_numb};
      3'd4:    alu_tmp = {1'b0, alu_numa | alu_numb};
      default: alu_tmp = 9'd0;
    endcase
  end
  assign alu_s    = alu_tmp[7:0];
  assign alu_co   = alu_tmp[8];
  assign alu_zero = (alu_tmp[7:0] == 8'd0);

  // Issue one request and return cycles from accept edge to done (-1 on timeout).
  // Entered and left #1 after a rising edge. If scramble is set, request
  // inputs are trashed right after accept.
  task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic scramble, output int lat);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      op = 3'd3; opa = ~a; opb = ~b;
    end
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", result); end
    n_checks++; if ({carry, zero, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {carry, zero, err}); end
    n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_done_busy got=%b exp=00", {done, busy}); end
    n_checks++; if ({alu_opt, alu_numa, alu_numb, alu_ci} !== 20'd0) begin n_fail++; $display("FAIL reset_alu_drive got=%h exp=0", {alu_opt, alu_numa, alu_numb, alu_ci}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    do_op(3'd1, 16'h00FF, 16'h0001, 1'b0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency got=%0d exp=3", lat); end
    n_checks++; if (result !== 16'h0100) begin n_fail++; $display("FAIL add_ff_result got=%h exp=0100", result); end
    n_checks++; if ({carry, zero, err} !== 3'b000) begin n_fail++; $display("FAIL add_ff_flags got=%b exp=000", {carry, zero, err}); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_in_done got=%b exp=1", busy); end
    @(posedge clk); #1;
    n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL add_done_pulse got=%b exp=00", {done, busy}); end
    do_op(3'd1, 16'hFFFF, 16'h0001, 1'b0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_wrap_latency got=%0d exp=3", lat); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL add_wrap_result got=%h exp=0000", result); end
    n_checks++; if ({carry, zero} !== 2'b11) begin n_fail++; $display("FAIL add_wrap_flags got=%b exp=11", {carry, zero}); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    int lat;
    do_op(3'd2, 16'h0000, 16'h0001, 1'b0, lat);
    n_checks++; if (result !== 16'hFFFF) begin n_fail++; $display("FAIL sub_borrow_result got=%h exp=ffff", result); end
    n_checks++; if ({carry, zero} !== 2'b10) begin n_fail++; $display("FAIL sub_borrow_flags got=%b exp=10", {carry, zero}); end
    @(posedge clk); #1;
    do_op(3'd2, 16'h0100, 16'h0001, 1'b0, lat);
    n_checks++; if (result !== 16'h00FF) begin n_fail++; $display("FAIL sub_chain_result got=%h exp=00ff", result); end
    n_checks++; if ({carry, zero} !== 2'b00) begin n_fail++; $display("FAIL sub_chain_flags got=%b exp=00", {carry, zero}); end
    @(posedge clk); #1;
  endtask

  // Relies on result 0x00FF left by test_sub.
  task automatic test_cmp();
    int lat;
    do_op(3'd5, 16'h1234, 16'h1234, 1'b0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL cmp_latency got=%0d exp=3", lat); end
    n_checks++; if (result !== 16'h00FF) begin n_fail++; $display("FAIL cmp_eq_result_held got=%h exp=00ff", result); end
    n_checks++; if ({carry, zero} !== 2'b01) begin n_fail++; $display("FAIL cmp_eq_flags got=%b exp=01", {carry, zero}); end
    @(posedge clk); #1;
    do_op(3'd5, 16'h1233, 16'h1234, 1'b0, lat);
    n_checks++; if (result !== 16'h00FF) begin n_fail++; $display("FAIL cmp_lt_result_held got=%h exp=00ff", result); end
    n_checks++; if ({carry, zero} !== 2'b10) begin n_fail++; $display("FAIL cmp_lt_flags got=%b exp=10", {carry, zero}); end
    @(posedge clk); #1;
  endtask

  // Relies on result 0x00FF, carry 1, zero 0 left by test_cmp.
  task automatic test_invalid();
    int lat;
    do_op(3'd6, 16'hAAAA, 16'h5555, 1'b0, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL inv_latency got=%0d exp=1", lat); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL inv_err got=%b exp=1", err); end
    n_checks++; if (result !== 16'h00FF) begin n_fail++; $display("FAIL inv_result_held got=%h exp=00ff", result); end
    n_checks++; if ({carry, zero} !== 2'b10) begin n_fail++; $display("FAIL inv_flags_held got=%b exp=10", {carry, zero}); end
    @(posedge clk); #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL inv_err_sticky got=%b exp=1", err); end
    do_op(3'd1, 16'h1234, 16'h1111, 1'b0, lat);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL add_clears_err got=%b exp=0", err); end
    n_checks++; if (result !== 16'h2345) begin n_fail++; $display("FAIL add_after_inv got=%h exp=2345", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_logic();
    int lat;
    do_op(3'd3, 16'hF0F0, 16'h0FF0, 1'b0, lat);
    n_checks++; if (result !== 16'h00F0) begin n_fail++; $display("FAIL and_result got=%h exp=00f0", result); end
    n_checks++; if ({carry, zero} !== 2'b00) begin n_fail++; $display("FAIL and_flags got=%b exp=00", {carry, zero}); end
    @(posedge clk); #1;
    do_op(3'd4, 16'h0000, 16'h0000, 1'b0, lat);
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL orr_result got=%h exp=0000", result); end
    n_checks++; if ({carry, zero} !== 2'b01) begin n_fail++; $display("FAIL orr_flags got=%b exp=01", {carry, zero}); end
    @(posedge clk); #1;
  endtask

  task automatic test_operand_change();
    int lat;
    do_op(3'd2, 16'h5000, 16'h1001, 1'b1, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL inflight_latency got=%0d exp=3", lat); end
    n_checks++; if (result !== 16'h3FFF) begin n_fail++; $display("FAIL inflight_result got=%h exp=3fff", result); end
    n_checks++; if ({carry, zero} !== 2'b00) begin n_fail++; $display("FAIL inflight_flags got=%b exp=00", {carry, zero}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ndone, first, last, busy_low;
    ndone = 0; first = -1; last = -1; busy_low = 0;
    op = 3'd1; opa = 16'h0001; opb = 16'h0002; start = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = i;
        last = i;
      end
      if (busy !== 1'b1) busy_low++;
    end
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (ndone !== 3) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
    n_checks++; if (first !== 3 || last !== 11) begin n_fail++; $display("FAIL b2b_done_spacing got=%0d,%0d exp=3,11", first, last); end
    n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL b2b_busy_gaps got=%0d exp=0", busy_low); end
    n_checks++; if (result !== 16'h0003) begin n_fail++; $display("FAIL b2b_result got=%h exp=0003", result); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    // result is 0x0003 here; abort an ADD while in HI.
    op = 3'd1; opa = 16'h0101; opb = 16'h0101; start = 1'b1;
    @(posedge clk); #1;              // accept -> LO
    start = 1'b0;
    @(posedge clk); #1;              // -> HI
    n_checks++; if (alu_numa !== 8'h01 || alu_opt !== 3'd1) begin n_fail++; $display("FAIL mid_hi_drive got=%h/%0d exp=01/1", alu_numa, alu_opt); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_done_busy got=%b exp=00", {done, busy}); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_result got=%h exp=0000", result); end
    n_checks++; if (alu_opt !== 3'd0) begin n_fail++; $display("FAIL mid_rst_idle got=%0d exp=0", alu_opt); end
    // rst wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_priority_busy got=%b exp=0", busy); end
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL mid_rst_no_done got=%0d exp=0", ndone); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    test_reset();
    test_add();
    test_sub();
    test_cmp();
    test_invalid();
    test_logic();
    test_operand_change();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  operation: 1 ADD, 2 SUB, 3 AND, 4 ORR, 5 CMP; 0, 6 and 7 invalid.
REQ-006 opa, opb  input  16 each  operands.
REQ-007 alu_opt  output  3  opcode driven to the 8-bit ALU, same encoding as op.
REQ-008 alu_numa, alu_numb  output  8 each  byte operands to the ALU.
REQ-009 alu_ci  output  1  carry/borrow in to the ALU.
REQ-010 alu_s  input  8  ALU result byte (combinational, same cycle).
REQ-011 alu_co, alu_zero  input  1 each  ALU carry/borrow out and zero.
REQ-012 busy  output  1  high from the cycle after accept until the cycle done is asserted, inclusive.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 result  output  16  registered result.
REQ-015 carry, zero, err  output  1 each  registered flags.

Function
REQ-016 FSM states SHALL be IDLE, LO, HI and FIN; after reset the state is IDLE.
REQ-017 In IDLE, when start=1, op, opa and opb SHALL be latched; a valid op goes to LO and an invalid op goes to FIN.
REQ-018 In IDLE, alu_opt, alu_numa, alu_numb and alu_ci SHALL be 0.
REQ-019 In LO, the ALU SHALL be driven with the latched op, opa[7:0], opb[7:0] and ci=0; alu_s, alu_co and alu_zero are captured as low byte, low carry and low zero; next state HI.
REQ-020 In HI, the ALU SHALL be driven with opa[15:8], opb[15:8] and ci set as follows:
  - ADD, SUB, CMP: ci = low carry.
  - AND, ORR: ci = 0.
  The high byte, high carry and high zero are captured; next state FIN.
REQ-021 SUB/CMP carry SHALL be interpreted as borrow: 1 when opa < opb unsigned; ADD carry is unsigned overflow out of bit 15; AND/ORR carry is 0.
REQ-022 In FIN, for a valid op:
  - done=1.
  - carry = high carry; zero = low zero AND high zero; err = 0.
  - result = {high byte, low byte}, except for CMP, where result holds its previous value.
  - Next state IDLE.
REQ-023 In FIN, for an invalid op: done=1, err=1, and result, carry and zero are unchanged; next state IDLE.
REQ-024 Latency: start accepted at edge N gives done high in cycle N+3 for a valid op and N+1 for an invalid op; outputs are valid from the same edge that raises done.
REQ-025 start SHALL be ignored while in LO, HI or FIN; no queuing; back-to-back requests are accepted no earlier than the cycle after done.
REQ-026 Changes on opa, opb or op after accept SHALL not affect the operation in flight.
REQ-027 result, carry, zero and err SHALL hold their values between operations.

Reset
REQ-028 When rst=1, at the next edge:
  - State goes to IDLE.
  - result=0x0000; carry, zero, err, done and busy = 0.
  - ALU drive outputs = 0.
REQ-029 Reset mid-operation (LO, HI or FIN) SHALL abort the operation without a done pulse; rst has priority over start in the same cycle.

Verification
REQ-030 ADD opa=0x00FF, opb=0x0001 -> result 0x0100, carry 0, zero 0, done exactly 3 cycles after accept.
REQ-031 ADD 0xFFFF+0x0001 -> result 0x0000, carry 1, zero 1; SUB 0x0000-0x0001 -> result 0xFFFF, carry 1; SUB 0x0100-0x0001 -> result 0x00FF, carry 0.
REQ-032 AND 0xF0F0&0x0FF0 -> result 0x00F0, carry 0; ORR 0x0000|0x0000 -> result 0x0000, zero 1.
REQ-033 After a result of 0x00FF, CMP 0x1234 vs 0x1234 -> result stays 0x00FF, zero 1, carry 0; CMP 0x1233 vs 0x1234 -> zero 0, carry 1.
REQ-034 op=6 with start -> done 1 cycle after accept, err 1, result and flags unchanged; a following valid ADD clears err.
REQ-035 start held high continuously yields one accept per 4 cycles; rst asserted in HI -> IDLE next cycle, no done pulse, result 0x0000.
